// File: rtl/timer_controller.sv
// Timer front-panel controller: conditions the raw pushbuttons and the counter's
// terminal-count flag, then sequences the minutes/seconds counter through
// idle, preset, run, pause and alarm phases. Every output comes straight from a flop.
module timer_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ALARM_CYCLES    = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_mode,
    input  logic       btn_sec,
    input  logic       btn_min,
    input  logic       finish,
    output logic       enable,
    output logic       forward,
    output logic       incrementSeconds,
    output logic       incrementMinutes,
    output logic       counter_clear,
    output logic       alarm,
    output logic [2:0] state
);

    // state  | meaning
    // IDLE   | counter held cleared, waiting for start or a preset button
    // SET    | presetting minutes/seconds while the buttons are held
    // RUN    | counter enabled
    // PAUSE  | counter frozen, terminal count ignored
    // ALARM  | terminal count reached; leaves on any press or timeout
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    localparam int B_START = 0;
    localparam int B_CLEAR = 1;
    localparam int B_MODE  = 2;
    localparam int B_SEC   = 3;
    localparam int B_MIN   = 4;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LOAD    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE     = DW'(1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);
    localparam logic [AW-1:0] ALM_ONE    = AW'(1);

    logic [4:0]    btn_raw;
    logic [4:0]    btn_s1;
    logic [4:0]    btn_s2;
    logic [1:0]    ready_sr;
    logic [4:0]    armed;
    logic [4:0]    db_level;
    logic [4:0]    db_prev;
    logic [DW-1:0] db_cnt [5];
    logic [4:0]    press;
    logic [4:0]    sel;
    logic          fin_s1;
    logic          fin_s2;
    logic          fin_prev;
    logic          fin_evt;
    logic [AW-1:0] alarm_timer;
    state_t        state_q;
    state_t        state_d;
    logic          fwd_d;

    assign btn_raw = {btn_min, btn_sec, btn_mode, btn_clear, btn_start};

    // Two-flop synchronizers for the buttons and the terminal-count flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            fin_s1   <= 1'b0;
            fin_s2   <= 1'b0;
            fin_prev <= 1'b0;
        end else begin
            btn_s1   <= btn_raw;
            btn_s2   <= btn_s1;
            fin_s1   <= finish;
            fin_s2   <= fin_s1;
            fin_prev <= fin_s2;
        end
    end

    assign fin_evt = fin_s2 & ~fin_prev;

    // A button only becomes armed once it has been seen released after reset,
    // so a button held through reset release never yields a press. The
    // synchronizer output is trusted only after it has refilled from reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_sr <= 2'b00;
            armed    <= '0;
        end else begin
            ready_sr <= {ready_sr[0], 1'b1};
            for (int i = 0; i < 5; i++) begin
                if (ready_sr[1] && !btn_s2[i]) armed[i] <= 1'b1;
            end
        end
    end

    // Debounce: a differing sample runs the down-counter; terminal count accepts the level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_level <= '0;
            db_prev  <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= DB_LOAD;
        end else begin
            db_prev <= db_level;
            for (int i = 0; i < 5; i++) begin
                if (btn_s2[i] == db_level[i]) begin
                    db_cnt[i] <= DB_LOAD;
                end else if (db_cnt[i] == '0) begin
                    db_level[i] <= btn_s2[i];
                    db_cnt[i]   <= DB_LOAD;
                end else begin
                    db_cnt[i] <= db_cnt[i] - DB_ONE;
                end
            end
        end
    end

    assign press = db_level & ~db_prev & armed;

    // Keep only the highest-priority press: clear > start > min > sec > mode.
    always_comb begin
        sel = '0;
        if (press[B_CLEAR])      sel[B_CLEAR] = 1'b1;
        else if (press[B_START]) sel[B_START] = 1'b1;
        else if (press[B_MIN])   sel[B_MIN]   = 1'b1;
        else if (press[B_SEC])   sel[B_SEC]   = 1'b1;
        else if (press[B_MODE])  sel[B_MODE]  = 1'b1;
    end

    // Alarm dwell timer: cleared outside ALARM, counts up and saturates inside.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_timer <= '0;
        end else if (state_q != ST_ALARM) begin
            alarm_timer <= '0;
        end else if (alarm_timer != ALARM_LAST) begin
            alarm_timer <= alarm_timer + ALM_ONE;
        end
    end

    // Next-state and direction decode.
    always_comb begin
        state_d = state_q;
        fwd_d   = forward;
        case (state_q)
            ST_IDLE: begin
                if (sel[B_START])                 state_d = ST_RUN;
                else if (sel[B_MIN] || sel[B_SEC]) state_d = ST_SET;
                else if (sel[B_MODE])             fwd_d   = ~forward;
            end
            ST_SET: begin
                if (sel[B_CLEAR])      state_d = ST_IDLE;
                else if (sel[B_START]) state_d = ST_RUN;
                else if (sel[B_MODE])  fwd_d   = ~forward;
            end
            ST_RUN: begin
                if (sel[B_CLEAR])      state_d = ST_IDLE;
                else if (fin_evt)      state_d = ST_ALARM;
                else if (sel[B_START]) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (sel[B_CLEAR])      state_d = ST_IDLE;
                else if (sel[B_START]) state_d = ST_RUN;
            end
            ST_ALARM: begin
                if ((|press) || (alarm_timer == ALARM_LAST)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered outputs, all decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            enable           <= 1'b0;
            counter_clear    <= 1'b1;
            alarm            <= 1'b0;
            forward          <= 1'b0;
            incrementSeconds <= 1'b0;
            incrementMinutes <= 1'b0;
        end else begin
            state_q          <= state_d;
            enable           <= (state_d == ST_RUN);
            counter_clear    <= (state_d == ST_IDLE);
            alarm            <= (state_d == ST_ALARM);
            forward          <= fwd_d;
            incrementSeconds <= (state_d == ST_SET) && db_level[B_SEC] && !db_level[B_MIN];
            incrementMinutes <= (state_d == ST_SET) && db_level[B_MIN] && !db_level[B_SEC];
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_timer_controller.sv
// Scoreboard bench for timer_controller with short debounce and alarm windows.
module tb_timer_controller;

    localparam int DB = 4;
    localparam int AL = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_sec = 1'b0;
    logic       btn_min = 1'b0;
    logic       finish = 1'b0;
    logic       enable;
    logic       forward;
    logic       incrementSeconds;
    logic       incrementMinutes;
    logic       counter_clear;
    logic       alarm;
    logic [2:0] state;

    timer_controller #(
        .DEBOUNCE_CYCLES(DB),
        .ALARM_CYCLES   (AL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .btn_start       (btn_start),
        .btn_clear       (btn_clear),
        .btn_mode        (btn_mode),
        .btn_sec         (btn_sec),
        .btn_min         (btn_min),
        .finish          (finish),
        .enable          (enable),
        .forward         (forward),
        .incrementSeconds(incrementSeconds),
        .incrementMinutes(incrementMinutes),
        .counter_clear   (counter_clear),
        .alarm           (alarm),
        .state           (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [8:0] obs;
    assign obs = {state, enable, counter_clear, alarm, forward, incrementSeconds, incrementMinutes};

    typedef struct {
        logic [8:0] v;
        int         cyc;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic fwd_m = 1'b0;
    bit   mon_on = 1'b0;

    function automatic logic [8:0] vec(logic [2:0] st, logic f, logic s, logic m);
        return {st, (st == 3'd2), (st == 3'd0), (st == 3'd4), f, s, m};
    endfunction

    task automatic check_vec(string name, logic [8:0] act, logic [8:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (state,en,clr,alarm,fwd,isec,imin)", name, act, req);
        end
    endtask

    task automatic check_int(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got cycle %0d required cycle %0d", name, act, req);
        end
    endtask

    task automatic push(string name, logic [2:0] st, logic s, logic m, int dcyc);
        exp_t e;
        e.v    = vec(st, fwd_m, s, m);
        e.cyc  = (dcyc < 0) ? -1 : cyc + dcyc;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(string name, int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout with %0d transitions outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every change of the observed output vector consumes one expectation.
    initial begin
        logic [8:0] last;
        exp_t       e;
        wait (mon_on);
        last = obs;
        forever begin
            @(negedge clk);
            if (obs !== last) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change: got %b from %b, required no change", obs, last);
                end else begin
                    e = exp_q.pop_front();
                    check_vec(e.name, obs, e.v);
                    if (e.cyc >= 0) check_int({e.name, "_cycle"}, cyc, e.cyc);
                end
                last = obs;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        cycles(3);
        check_vec("reset_state", obs, vec(3'd0, 1'b0, 1'b0, 1'b0));
        reset = 1'b1;
        cycles(4);
        mon_on = 1'b1;

        // short glitch must not be accepted
        btn_start = 1'b1;
        cycles(3);
        btn_start = 1'b0;
        cycles(12);
        check_vec("glitch_no_press", obs, vec(3'd0, fwd_m, 1'b0, 1'b0));

        // start press: 2 sync + 4 debounce + 1 register
        btn_start = 1'b1;
        push("idle_to_run", 3'd2, 1'b0, 1'b0, 7);
        cycles(10);
        btn_start = 1'b0;
        wait_drain("idle_to_run", 20);
        cycles(10);

        // finish edge -> ALARM in 3 cycles, timeout back to IDLE 20 later
        finish = 1'b1;
        push("run_to_alarm", 3'd4, 1'b0, 1'b0, 3);
        push("alarm_timeout", 3'd0, 1'b0, 1'b0, 3 + AL);
        cycles(5);
        finish = 1'b0;
        wait_drain("alarm_timeout", 40);
        cycles(3);

        // seconds preset held, released
        btn_sec = 1'b1;
        push("idle_to_set", 3'd1, 1'b1, 1'b0, 7);
        cycles(30);
        btn_sec = 1'b0;
        push("sec_release", 3'd1, 1'b0, 1'b0, 7);
        wait_drain("sec_release", 20);
        cycles(3);

        // mode in SET toggles direction
        btn_mode = 1'b1;
        fwd_m = 1'b1;
        push("set_mode_toggle", 3'd1, 1'b0, 1'b0, 7);
        cycles(8);
        btn_mode = 1'b0;
        wait_drain("set_mode_toggle", 20);
        cycles(10);

        btn_start = 1'b1;
        push("set_to_run", 3'd2, 1'b0, 1'b0, 7);
        cycles(8);
        btn_start = 1'b0;
        wait_drain("set_to_run", 20);
        cycles(10);

        // mode in RUN ignored
        btn_mode = 1'b1;
        cycles(8);
        btn_mode = 1'b0;
        cycles(10);
        check_vec("run_mode_ignored", obs, vec(3'd2, fwd_m, 1'b0, 1'b0));

        btn_start = 1'b1;
        push("run_to_pause", 3'd3, 1'b0, 1'b0, 7);
        cycles(8);
        btn_start = 1'b0;
        wait_drain("run_to_pause", 20);
        cycles(10);

        // finish ignored in PAUSE
        finish = 1'b1;
        cycles(5);
        finish = 1'b0;
        cycles(5);
        check_vec("pause_finish_ignored", obs, vec(3'd3, fwd_m, 1'b0, 1'b0));

        btn_start = 1'b1;
        push("pause_to_run", 3'd2, 1'b0, 1'b0, 7);
        cycles(8);
        btn_start = 1'b0;
        wait_drain("pause_to_run", 20);
        cycles(10);

        // clear and start together: clear wins, direction kept
        btn_clear = 1'b1;
        btn_start = 1'b1;
        push("clear_wins", 3'd0, 1'b0, 1'b0, 7);
        cycles(8);
        btn_clear = 1'b0;
        btn_start = 1'b0;
        wait_drain("clear_wins", 20);
        cycles(10);

        // press in ALARM returns to IDLE and is consumed
        btn_start = 1'b1;
        push("idle_to_run2", 3'd2, 1'b0, 1'b0, 7);
        cycles(8);
        btn_start = 1'b0;
        wait_drain("idle_to_run2", 20);
        cycles(10);
        finish = 1'b1;
        push("run_to_alarm2", 3'd4, 1'b0, 1'b0, 3);
        wait_drain("run_to_alarm2", 10);
        finish = 1'b0;
        btn_start = 1'b1;
        push("alarm_press_exit", 3'd0, 1'b0, 1'b0, 7);
        cycles(8);
        btn_start = 1'b0;
        wait_drain("alarm_press_exit", 20);
        cycles(15);
        check_vec("alarm_press_consumed", obs, vec(3'd0, fwd_m, 1'b0, 1'b0));

        // reset pulse in ALARM, button and finish held through release
        btn_start = 1'b1;
        push("idle_to_run3", 3'd2, 1'b0, 1'b0, 7);
        cycles(8);
        btn_start = 1'b0;
        wait_drain("idle_to_run3", 20);
        cycles(10);
        finish = 1'b1;
        push("run_to_alarm3", 3'd4, 1'b0, 1'b0, 3);
        wait_drain("run_to_alarm3", 10);
        fwd_m = 1'b0;
        push("reset_mid_alarm", 3'd0, 1'b0, 1'b0, -1);
        #2;
        reset = 1'b0;
        btn_start = 1'b1;
        #1;
        check_vec("reset_async", obs, vec(3'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        #2;
        reset = 1'b1;
        cycles(15);
        check_vec("held_through_reset", obs, vec(3'd0, 1'b0, 1'b0, 1'b0));
        btn_start = 1'b0;
        finish = 1'b0;
        cycles(10);
        btn_start = 1'b1;
        push("rearmed_run", 3'd2, 1'b0, 1'b0, 7);
        cycles(8);
        btn_start = 1'b0;
        wait_drain("rearmed_run", 20);
        cycles(10);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover: %0d expectations unconsumed, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_controller.md
TIMER_CONTROLLER -- requirements
Module: timer_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles before a button level is accepted (10 ms at 100 MHz).
REQ-002 Parameter ALARM_CYCLES, default 500000000, maximum cycles the ALARM state persists (5 s at 100 MHz).
REQ-003 clk  input  1  system clock, 100 MHz; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-005 btn_start  input  1  raw start/stop pushbutton, asynchronous, active-high.
REQ-006 btn_clear  input  1  raw clear pushbutton, asynchronous, active-high.
REQ-007 btn_mode  input  1  raw count-direction toggle pushbutton, asynchronous, active-high.
REQ-008 btn_sec  input  1  raw set-seconds pushbutton, asynchronous, active-high.
REQ-009 btn_min  input  1  raw set-minutes pushbutton, asynchronous, active-high.
REQ-010 finish  input  1  terminal-count flag from the minutes/seconds counter, asynchronous to clk.
REQ-011 enable  output  1  counter run enable.
REQ-012 forward  output  1  counter direction, 1 = count up, 0 = count down.
REQ-013 incrementSeconds  output  1  seconds preset increment request to counter.
REQ-014 incrementMinutes  output  1  minutes preset increment request to counter.
REQ-015 counter_clear  output  1  active-high clear to counter.
REQ-016 alarm  output  1  terminal-count indicator for buzzer/LED.
REQ-017 state  output  3  current FSM state encoding for display/debug.

Function
REQ-018 Each btn_* input SHALL pass a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-019 A "press" SHALL be a one-cycle pulse on the debounced 0->1 transition; release generates nothing.
REQ-020 finish SHALL pass a 2-flop synchronizer; a "finish event" is its synchronized 0->1 edge.
REQ-021 States and encodings SHALL be IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4; encodings 5-7 SHALL return to IDLE next cycle.
REQ-022 Simultaneous presses in one cycle SHALL be prioritized clear > start > min > sec > mode; only the highest is acted on, the rest are discarded.
REQ-023 IDLE: start -> RUN; sec or min press -> SET; mode press toggles forward, stays IDLE.
REQ-024 SET: start -> RUN; clear -> IDLE; mode press toggles forward; sec/min presses stay in SET.
REQ-025 RUN: start -> PAUSE; clear -> IDLE; finish event -> ALARM; finish event and start in same cycle -> ALARM; mode press ignored.
REQ-026 PAUSE: start -> RUN; clear -> IDLE; finish events ignored; mode ignored.
REQ-027 ALARM: any press, or ALARM_CYCLES elapsed since entry -> IDLE; the press is consumed (not also acted on in IDLE).
REQ-028 enable SHALL be 1 exactly while state is RUN.
REQ-029 counter_clear SHALL be 1 exactly while state is IDLE (counter held at zero in IDLE).
REQ-030 alarm SHALL be 1 exactly while state is ALARM.
REQ-031 incrementSeconds SHALL be 1 while state is SET and debounced btn_sec level is 1 and btn_min level is 0; incrementMinutes likewise for btn_min; both held never assert together.
REQ-032 forward SHALL change only on an accepted mode press in IDLE or SET.
REQ-033 All outputs SHALL be registered (no combinational path from any input to any output).
REQ-034 The ALARM timer SHALL be wide enough for ALARM_CYCLES, reload to 0 on ALARM entry and not wrap.

Reset
REQ-035 On reset=0: state=IDLE, enable=0, counter_clear=1, alarm=0, forward=0, incrementSeconds=0, incrementMinutes=0, debouncers and synchronizers to 0, ALARM timer to 0.
REQ-036 Reset mid-RUN or mid-ALARM SHALL take effect asynchronously with no residual press, finish event or alarm after release.
REQ-037 A button held through reset release SHALL NOT produce a press until released and pressed again.

Verification (DEBOUNCE_CYCLES=4, ALARM_CYCLES=20)
REQ-038 Reset, btn_start high 10 cycles -> state 0->2 after 2+4+1 cycles; enable=1, counter_clear=0.
REQ-039 btn_start glitch of 3 cycles high -> no press, state stays IDLE.
REQ-040 IDLE, press btn_sec, hold 30 cycles -> state=SET; incrementSeconds=1 while held, 0 one cycle after debounced release.
REQ-041 RUN, finish 0->1 -> ALARM within 3 cycles, enable=0, alarm=1; no input -> IDLE after 20 cycles, counter_clear=1.
REQ-042 RUN, btn_clear and btn_start pressed together -> IDLE (clear wins), forward unchanged.
REQ-043 ALARM, reset pulsed low 1 cycle -> alarm=0 immediately, state=0, forward=0.
